// File: rtl/program_request_ctl_pkg.sv
// Shared definitions for the program request front end: FSM encoding and the
// program ids that the regfile program decode also uses.
package program_request_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_CRST    = 2'd3
  } state_t;

  localparam int PROG_NONE = 0;
  localparam int PROG_FIB  = 1;
  localparam int PROG_SORT = 2;
  localparam int PROG_SAVE = 3;
  localparam int PROG_LOAD = 4;

endpackage

// File: rtl/program_request_ctl_debounce_ch.sv
// One debounce channel: 2-flop synchroniser followed by a stability counter.
// The level only changes after DB_CYCLES consecutive disagreeing samples.
module program_request_ctl_debounce_ch #(
  parameter int DB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Synchroniser stages, then the stability counter on the synchronised level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/program_request_ctl.sv
// Push-button front end: debounces program and core-reset buttons, issues a held
// prog_sel request with req/ack handshake and a core_reset pulse.
// Define PROGRAM_REQUEST_QUEUE_EN to add a one-deep pending request slot.
module program_request_ctl
  import program_request_ctl_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int SEL_W      = 32,
  parameter int DB_CYCLES  = 4,
  parameter int HOLD_MIN   = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  input  logic             btn_core_reset,
  input  logic             prog_ack,
  output logic [SEL_W-1:0] prog_sel,
  output logic             prog_busy,
  output logic             core_reset,
  output logic [N_BTN-1:0] btn_db
);

  localparam int HOLD_W = $clog2(HOLD_MIN + 1);
  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MIN - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MIN);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES);
  localparam logic [SEL_W-1:0]  SEL_NONE  = SEL_W'(PROG_NONE);

  logic              core_db;
  logic              core_db_p1;
  logic [N_BTN-1:0]  db_p1;
  logic [N_BTN-1:0]  press;
  logic              core_rise;
  logic              press_any;
  logic [SEL_W-1:0]  press_id;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              ack_seen, ack_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_nxt;
  logic              crst_nxt;
`ifdef PROGRAM_REQUEST_QUEUE_EN
  logic [SEL_W-1:0]  pend_sel, pend_nxt;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    program_request_ctl_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn[i]),
      .level   (btn_db[i])
    );
  end

  program_request_ctl_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db_core (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_core_reset),
    .level   (core_db)
  );

  // Edge detection against a one-cycle delayed copy of the debounced levels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_p1      <= '0;
      core_db_p1 <= 1'b0;
    end else begin
      db_p1      <= btn_db;
      core_db_p1 <= core_db;
    end
  end

  assign press     = btn_db & ~db_p1;
  assign core_rise = core_db & ~core_db_p1;

  // Scan downwards so the lowest-index channel is the one left standing
  always_comb begin
    press_any = 1'b0;
    press_id  = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_any = 1'b1;
        press_id  = SEL_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = prog_sel;
    hold_nxt  = hold_cnt;
    ack_nxt   = ack_seen;
    rst_nxt   = rst_cnt;
    crst_nxt  = core_reset;
`ifdef PROGRAM_REQUEST_QUEUE_EN
    pend_nxt  = pend_sel;
`endif
    if (core_rise) begin
      state_nxt = ST_CRST;
      sel_nxt   = SEL_NONE;
      rst_nxt   = '0;
      crst_nxt  = 1'b0;
`ifdef PROGRAM_REQUEST_QUEUE_EN
      pend_nxt  = SEL_NONE;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
`ifdef PROGRAM_REQUEST_QUEUE_EN
          if (pend_sel != SEL_NONE) begin
            state_nxt = ST_HOLD;
            sel_nxt   = pend_sel;
            hold_nxt  = '0;
            ack_nxt   = 1'b0;
            pend_nxt  = SEL_NONE;
          end else
`endif
          if (press_any) begin
            state_nxt = ST_HOLD;
            sel_nxt   = press_id;
            hold_nxt  = '0;
            ack_nxt   = 1'b0;
          end
        end
        ST_HOLD: begin
          if ((prog_ack || ack_seen) && hold_cnt >= HOLD_LAST) begin
            state_nxt = ST_RELEASE;
            sel_nxt   = SEL_NONE;
          end else begin
            if (hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + 1'b1;
            if (prog_ack) ack_nxt = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (btn_db == '0) state_nxt = ST_IDLE;
        end
        ST_CRST: begin
          if (rst_cnt == RST_LAST) begin
            state_nxt = ST_RELEASE;
            crst_nxt  = 1'b0;
          end else begin
            crst_nxt  = 1'b1;
            rst_nxt   = rst_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
`ifdef PROGRAM_REQUEST_QUEUE_EN
      // Only the first press seen during a handshake is kept
      if ((state == ST_HOLD || state == ST_RELEASE) && press_any && pend_sel == SEL_NONE)
        pend_nxt = press_id;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      prog_sel   <= '0;
      prog_busy  <= 1'b0;
      core_reset <= 1'b0;
      hold_cnt   <= '0;
      ack_seen   <= 1'b0;
      rst_cnt    <= '0;
`ifdef PROGRAM_REQUEST_QUEUE_EN
      pend_sel   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      prog_sel   <= sel_nxt;
      prog_busy  <= (state_nxt != ST_IDLE);
      core_reset <= crst_nxt;
      hold_cnt   <= hold_nxt;
      ack_seen   <= ack_nxt;
      rst_cnt    <= rst_nxt;
`ifdef PROGRAM_REQUEST_QUEUE_EN
      pend_sel   <= pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_program_request_ctl.sv
// Bench for program_request_ctl: two instances (HOLD_MIN 2 and 3) share stimulus
// and are compared each cycle against a behavioural model, plus directed sequences.
module tb_program_request_ctl;

  localparam int N_BTN = 4;
  localparam int SEL_W = 32;
  localparam int DB    = 4;
  localparam int RSTC  = 4;
  localparam int N_TV  = 28;
`ifdef PROGRAM_REQUEST_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif
  localparam int M_IDLE = 0, M_HOLD = 1, M_REL = 2, M_CRST = 3;

  typedef struct {
    logic [3:0]  btn;
    logic        ack;
    logic [31:0] sel;
    logic        busy;
    logic [3:0]  db;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N_BTN-1:0] btn;
  logic             btn_core_reset;
  logic             prog_ack;
  logic [SEL_W-1:0] sel0, sel1;
  logic             busy0, busy1, cr0, cr1;
  logic [N_BTN-1:0] db0, db1;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tv [N_TV];

  always #5 clock = ~clock;

  program_request_ctl #(.N_BTN(N_BTN), .SEL_W(SEL_W), .DB_CYCLES(DB), .HOLD_MIN(2), .RST_CYCLES(RSTC)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .btn(btn), .btn_core_reset(btn_core_reset),
    .prog_ack(prog_ack), .prog_sel(sel0), .prog_busy(busy0), .core_reset(cr0), .btn_db(db0));

  program_request_ctl #(.N_BTN(N_BTN), .SEL_W(SEL_W), .DB_CYCLES(DB), .HOLD_MIN(3), .RST_CYCLES(RSTC)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .btn(btn), .btn_core_reset(btn_core_reset),
    .prog_ack(prog_ack), .prog_sel(sel1), .prog_busy(busy1), .core_reset(cr1), .btn_db(db1));

  // Reference model: channels 0..3 are program buttons, channel 4 is core reset
  bit m_s1 [5], m_s2 [5], m_stab [5], m_prev [5];
  int m_run [5];
  int m_mode [2], m_sel [2], m_held [2], m_rcnt [2], m_pend [2];
  bit m_acked [2], m_cr [2];

  function automatic int hold_min(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_prev[c] = 0; m_run[c] = 0;
    end
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = M_IDLE; m_sel[m] = 0; m_held[m] = 0; m_rcnt[m] = 0;
      m_pend[m] = 0; m_acked[m] = 0; m_cr[m] = 0;
    end
  endtask

  task automatic enter_hold(input int m, input int id);
    m_mode[m] = M_HOLD; m_sel[m] = id; m_held[m] = 0; m_acked[m] = 0;
  endtask

  task automatic model_step();
    bit rise [5];
    bit any_db;
    int pid, old;
    if (!reset_n) begin
      model_reset();
      return;
    end
    any_db = 0;
    pid = 0;
    for (int c = 0; c < 5; c++) rise[c] = m_stab[c] && !m_prev[c];
    for (int c = 0; c < N_BTN; c++) begin
      if (rise[c] && pid == 0) pid = c + 1;
      any_db = any_db | m_stab[c];
    end
    for (int m = 0; m < 2; m++) begin
      old = m_mode[m];
      if (rise[N_BTN]) begin
        m_mode[m] = M_CRST; m_sel[m] = 0; m_rcnt[m] = 0; m_cr[m] = 0; m_pend[m] = 0;
      end else begin
        case (old)
          M_IDLE: begin
            if (m_pend[m] != 0) begin
              enter_hold(m, m_pend[m]);
              m_pend[m] = 0;
            end else if (pid != 0) begin
              enter_hold(m, pid);
            end
          end
          M_HOLD: begin
            // hold cycles completed so far, including this one, must reach HOLD_MIN
            if ((prog_ack || m_acked[m]) && m_held[m] + 1 >= hold_min(m)) begin
              m_mode[m] = M_REL; m_sel[m] = 0;
            end else begin
              if (m_held[m] < hold_min(m)) m_held[m]++;
              if (prog_ack) m_acked[m] = 1;
            end
          end
          M_REL: if (!any_db) m_mode[m] = M_IDLE;
          default: begin
            if (m_rcnt[m] < RSTC) begin
              m_cr[m] = 1; m_rcnt[m]++;
            end else begin
              m_cr[m] = 0; m_mode[m] = M_REL;
            end
          end
        endcase
        if (QUEUE && (old == M_HOLD || old == M_REL) && pid != 0 && m_pend[m] == 0)
          m_pend[m] = pid;
      end
    end
    // Level flips once the synchronised input has disagreed for DB cycles in a row
    for (int c = 0; c < 5; c++) begin
      m_prev[c] = m_stab[c];
      if (m_s2[c] != m_stab[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_stab[c] = m_s2[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = (c < N_BTN) ? btn[c] : btn_core_reset;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_db;
    for (int c = 0; c < N_BTN; c++) e_db[c] = m_stab[c];
    check("sel0",  sel0, 32'(m_sel[0]));
    check("busy0", 32'(busy0), 32'(m_mode[0] != M_IDLE));
    check("crst0", 32'(cr0), 32'(m_cr[0]));
    check("db0",   32'(db0), 32'(e_db));
    check("sel1",  sel1, 32'(m_sel[1]));
    check("busy1", 32'(busy1), 32'(m_mode[1] != M_IDLE));
    check("crst1", 32'(cr1), 32'(m_cr[1]));
    check("db1",   32'(db1), 32'(e_db));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic wait_sel0(input int v, input string name);
    bit hit;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = (sel0 == v);
    end
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: prog_sel never reached %0d within 40 cycles", name, v);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen2, seen4, seen3, sel_in_crst;
    int len0, len1, ncr0, ncr1;

    // Clean press on btn[0], ack in the third HOLD cycle, release after 20 cycles
    for (int i = 0; i < N_TV; i++) begin
      tv[i].btn  = (i < 20) ? 4'b0001 : 4'b0000;
      tv[i].ack  = (i == 9);
      tv[i].sel  = (i >= 6 && i <= 8) ? 32'd1 : 32'd0;
      tv[i].busy = (i >= 6 && i <= 25);
      tv[i].db   = (i >= 5 && i <= 24) ? 4'b0001 : 4'b0000;
    end

    btn = '0; btn_core_reset = 0; prog_ack = 0; reset_n = 0;
    model_reset();
    repeat (3) tick();
    reset_n = 1;
    repeat (2) tick();

    for (int i = 0; i < N_TV; i++) begin
      btn = tv[i].btn;
      prog_ack = tv[i].ack;
      tick();
      check("tbl_sel",  sel0, tv[i].sel);
      check("tbl_busy", 32'(busy0), 32'(tv[i].busy));
      check("tbl_db",   32'(db0), 32'(tv[i].db));
    end
    btn = '0; prog_ack = 0;
    repeat (2) tick();

    // Two-cycle glitch on btn[1]
    btn = 4'b0010;
    repeat (2) tick();
    btn = '0;
    repeat (10) begin
      tick();
      check("glitch_db1", 32'(db0[1]), 32'd0);
      check("glitch_sel", sel0, 32'd0);
    end

    // Simultaneous rise of btn[3] and btn[1]
    seen2 = 0; seen4 = 0;
    btn = 4'b1010; prog_ack = 1;
    for (int k = 0; k < 26; k++) begin
      if (k == 14) btn = '0;
      tick();
      if (sel0 == 2) seen2 = 1;
      if (sel0 == 4 || sel1 == 4) seen4 = 1;
    end
    prog_ack = 0;
    check("simul_got_prog2", 32'(seen2), 32'd1);
    check("simul_no_prog4", 32'(seen4), 32'd0);

    // Ack already high when HOLD is entered
    len0 = 0; len1 = 0;
    prog_ack = 1; btn = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      if (k == 20) btn = '0;
      tick();
      if (sel0 != 0) len0++;
      if (sel1 != 0) len1++;
    end
    prog_ack = 0;
    check("early_ack_len_hm2", 32'(len0), 32'd2);
    check("early_ack_len_hm3", 32'(len1), 32'd3);

    // Core reset during HOLD of program 3
    btn = 4'b0100;
    wait_sel0(3, "crst_wait_prog3");
    btn_core_reset = 1;
    ncr0 = 0; ncr1 = 0; sel_in_crst = 0;
    repeat (14) begin
      tick();
      if (cr0) ncr0++;
      if (cr1) ncr1++;
      if (cr0 && sel0 != 0) sel_in_crst = 1;
    end
    btn_core_reset = 0; btn = '0;
    repeat (12) tick();
    check("crst_len0", 32'(ncr0), 32'd4);
    check("crst_len1", 32'(ncr1), 32'd4);
    check("crst_sel_cleared", 32'(sel_in_crst), 32'd0);
    check("crst_back_idle", 32'(busy0), 32'd0);

    // Asynchronous reset mid-HOLD, sampled with no clock edge in between
    btn = 4'b0001;
    wait_sel0(1, "async_wait_prog1");
    #2 reset_n = 0;
    #1;
    model_reset();
    compare_all();
    check("async_sel", sel0, 32'd0);
    tick();
    reset_n = 1;
    repeat (10) tick();
    prog_ack = 1;
    repeat (4) tick();
    btn = '0; prog_ack = 0;
    repeat (12) tick();

    // Press btn[2] while program 1 is held
    seen3 = 0;
    btn = 4'b0001;
    wait_sel0(1, "queue_wait_prog1");
    btn = 4'b0101;
    repeat (8) tick();
    prog_ack = 1; btn = '0;
    repeat (30) begin
      tick();
      if (sel0 == 3) seen3 = 1;
    end
    prog_ack = 0;
    check("queue_prog3_issued", 32'(seen3), 32'(QUEUE));
    repeat (10) tick();

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 59) == 0) btn_core_reset = ~btn_core_reset;
      prog_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    btn = '0; btn_core_reset = 0; prog_ack = 1;
    repeat (30) tick();
    check("final_idle", 32'(busy0 | busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
